// File: rtl/alu_mul_sequencer.sv
// Iterative shift-add multiplier that borrows the shared pipeline ALU for each
// add step. The EX stage keeps priority through alu_gnt; the low WIDTH product bits are returned.
module alu_mul_sequencer #(
    parameter int WIDTH      = 32,
    parameter int CNT_W      = 6,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_signal,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             alu_req_q, alu_req_d;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    cnt_d    = '0;
                    state_d  = S_ITER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                // Early exit needs no grant: nothing is added on this cycle
                if ((EARLY_EXIT == 1) && (mplier_q == '0)) begin
                    state_d = S_DONE;
                end else if (alu_gnt) begin
                    if (mplier_q[0]) begin
                        acc_d = alu_result;
                    end else begin
                        acc_d = acc_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ITER;
                    end
                end else begin
                    state_d = S_ITER;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if ((state_q == S_ITER) && (state_d == S_DONE)) begin
            product_d = acc_d;
        end else begin
            product_d = product_q;
        end
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        alu_req_d = (state_d == S_ITER);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alu_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            alu_req_q <= alu_req_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign product    = product_q;
    assign alu_req    = alu_req_q;
    assign alu_a      = acc_q;
    assign alu_b      = mcand_q;
    assign alu_signal = 3'b010;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: one instance without and one with early exit,
// each fed by a behavioural ALU and checked against an arithmetic reference model.
module tb_alu_mul_sequencer;

    logic        clk;
    logic        rst_n_s   [2];
    logic        start_s   [2];
    logic [31:0] op_a_s    [2];
    logic [31:0] op_b_s    [2];
    logic        gnt_s     [2];
    logic [31:0] alu_res_s [2];
    logic        busy_w    [2];
    logic        done_w    [2];
    logic [31:0] prod_w    [2];
    logic        req_w     [2];
    logic [31:0] alu_a_w   [2];
    logic [31:0] alu_b_w   [2];
    logic [2:0]  sig_w     [2];

    int checks = 0;
    int errors = 0;

    alu_mul_sequencer #(.WIDTH(32), .CNT_W(6), .EARLY_EXIT(0)) u_dut0 (
        .clk(clk), .reset_n(rst_n_s[0]), .start(start_s[0]),
        .op_a(op_a_s[0]), .op_b(op_b_s[0]), .busy(busy_w[0]), .done(done_w[0]),
        .product(prod_w[0]), .alu_req(req_w[0]), .alu_gnt(gnt_s[0]),
        .alu_a(alu_a_w[0]), .alu_b(alu_b_w[0]), .alu_signal(sig_w[0]),
        .alu_result(alu_res_s[0])
    );

    alu_mul_sequencer #(.WIDTH(32), .CNT_W(6), .EARLY_EXIT(1)) u_dut1 (
        .clk(clk), .reset_n(rst_n_s[1]), .start(start_s[1]),
        .op_a(op_a_s[1]), .op_b(op_b_s[1]), .busy(busy_w[1]), .done(done_w[1]),
        .product(prod_w[1]), .alu_req(req_w[1]), .alu_gnt(gnt_s[1]),
        .alu_a(alu_a_w[1]), .alu_b(alu_b_w[1]), .alu_signal(sig_w[1]),
        .alu_result(alu_res_s[1])
    );

    // Shared ALU performing ADD combinationally
    assign alu_res_s[0] = alu_a_w[0] + alu_b_w[0];
    assign alu_res_s[1] = alu_a_w[1] + alu_b_w[1];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycles from the start edge until done is visible: one per ITER cycle.
    function automatic int model_lat(input bit ee, input logic [31:0] b, input logic [255:0] m);
        int need;
        int cyc;
        int g;
        need = 32;
        if (ee) begin
            need = 0;
            for (int i = 0; i < 32; i++) if (b[i]) need = i + 1;
        end
        cyc = 0;
        g   = 0;
        while (g < need) begin
            cyc++;
            if (!m[cyc]) g++;
        end
        if (ee && need < 32) cyc++;
        return cyc;
    endfunction

    task automatic run_mul(input int inst, input logic [31:0] a, input logic [31:0] b,
                           input logic [255:0] mask, input int pulse_cyc, input string tag);
        int          lat;
        int          exp_lat;
        logic [31:0] exp_p;
        logic [31:0] sa;
        logic [31:0] sb;
        exp_lat = model_lat(inst == 1, b, mask);
        exp_p   = a * b;
        lat     = -1;
        @(negedge clk);
        op_a_s[inst]  = a;
        op_b_s[inst]  = b;
        start_s[inst] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start_s[inst] = (c == pulse_cyc);
            if (c == pulse_cyc) begin
                op_a_s[inst] = 32'd9;
                op_b_s[inst] = 32'd9;
            end
            gnt_s[inst] = ~mask[c];
            sa = alu_a_w[inst];
            sb = alu_b_w[inst];
            if (c == 1) begin
                check({tag, " busy_iter"}, {63'd0, busy_w[inst]}, 64'd1);
                check({tag, " req_iter"}, {63'd0, req_w[inst]}, 64'd1);
                check({tag, " signal"}, {61'd0, sig_w[inst]}, 64'd2);
            end
            @(posedge clk);
            #1;
            if (done_w[inst]) begin
                lat = c;
                break;
            end
            if (mask[c]) begin
                check({tag, " stall_acc"}, {32'd0, alu_a_w[inst]}, {32'd0, sa});
                check({tag, " stall_mcand"}, {32'd0, alu_b_w[inst]}, {32'd0, sb});
            end
        end
        start_s[inst] = 1'b0;
        gnt_s[inst]   = 1'b1;
        if (lat < 0) begin
            check({tag, " timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, " latency"}, 64'(lat), 64'(exp_lat));
            check({tag, " product"}, {32'd0, prod_w[inst]}, {32'd0, exp_p});
            check({tag, " busy_done"}, {63'd0, busy_w[inst]}, 64'd1);
            check({tag, " req_done"}, {63'd0, req_w[inst]}, 64'd0);
            @(posedge clk);
            #1;
            check({tag, " done_pulse"}, {63'd0, done_w[inst]}, 64'd0);
            check({tag, " idle_busy"}, {63'd0, busy_w[inst]}, 64'd0);
            check({tag, " product_hold"}, {32'd0, prod_w[inst]}, {32'd0, exp_p});
        end
    endtask

    initial begin
        logic [255:0] m;
        logic [31:0]  ra;
        logic [31:0]  rb;
        bit           seen_done;
        clk = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rst_n_s[i] = 1'b0;
            start_s[i] = 1'b0;
            op_a_s[i]  = 32'd0;
            op_b_s[i]  = 32'd0;
            gnt_s[i]   = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n_s[0] = 1'b1;
        rst_n_s[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("reset busy", {63'd0, busy_w[i]}, 64'd0);
            check("reset done", {63'd0, done_w[i]}, 64'd0);
            check("reset req", {63'd0, req_w[i]}, 64'd0);
            check("reset product", {32'd0, prod_w[i]}, 64'd0);
        end

        // Directed cases
        run_mul(0, 32'd3, 32'd5, 256'd0, 0, "d0_3x5");
        run_mul(0, 32'hFFFF_FFFF, 32'd2, 256'd0, 0, "d0_ffx2");
        run_mul(0, 32'h8000_0000, 32'h8000_0000, 256'd0, 0, "d0_wrap");
        run_mul(1, 32'd7, 32'd1, 256'd0, 0, "d1_7x1");
        m = '1;
        run_mul(1, 32'd5, 32'd0, m, 0, "d1_bzero_nognt");
        m = '0;
        for (int j = 3; j <= 7; j++) m[j] = 1'b1;
        run_mul(0, 32'd10, 32'd6, m, 0, "d0_stall");
        run_mul(1, 32'd10, 32'd6, m, 0, "d1_stall");
        run_mul(0, 32'd4, 32'd4, 256'd0, 10, "d0_busy_start");
        run_mul(0, 32'd2, 32'd11, 256'd0, 0, "d0_after_busy");
        run_mul(1, 32'hFFFF_FFFF, 32'h8000_0001, 256'd0, 0, "d1_topbit");

        // Reset mid-operation on the non-early-exit instance
        @(negedge clk);
        op_a_s[0]  = 32'd5;
        op_b_s[0]  = 32'd5;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst_n_s[0] = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid busy", {63'd0, busy_w[0]}, 64'd0);
        check("rst_mid product", {32'd0, prod_w[0]}, 64'd0);
        check("rst_mid req", {63'd0, req_w[0]}, 64'd0);
        @(negedge clk);
        rst_n_s[0] = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done_w[0]) seen_done = 1'b1;
        end
        check("rst_mid no_done", {63'd0, seen_done}, 64'd0);
        run_mul(0, 32'd6, 32'd7, 256'd0, 0, "d0_after_rst");

        // Randomized operands and grant stalls on both instances
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            m  = '0;
            for (int j = 1; j <= 40; j++) m[j] = ($urandom_range(0, 7) == 0);
            run_mul(n % 2, ra, rb, m, 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
